// File: rtl/shift_pkg.sv
// Shared definitions for the parallel register stage and the serializer behind it.
// Holds the serializer state encoding and the default word width.
package shift_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Word width shared with the upstream parallel register stage.
    localparam int unsigned DEFAULT_WIDTH = 4;

    // Bit counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry hold buffer in front of the shifter: stores one parallel word while the
// current word is still shifting, and derives in_ready from its occupancy.
module piso_hold_buf
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             pop,
    output logic [WIDTH-1:0] hreg,
    output logic             hfull,
    output logic             in_ready
);

    logic [WIDTH-1:0] hreg_q, hreg_d;
    logic             hfull_q, hfull_d;

    // load only happens while empty and pop only while full, so they never collide.
    always_comb begin
        hreg_d  = hreg_q;
        hfull_d = hfull_q;
        if (load) begin
            hreg_d  = in;
            hfull_d = 1'b1;
        end else if (pop) begin
            hfull_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hreg_q  <= '0;
            hfull_q <= 1'b0;
        end else begin
            hreg_q  <= hreg_d;
            hfull_q <= hfull_d;
        end
    end

    assign hreg     = hreg_q;
    assign hfull    = hfull_q;
    // Registered-only path: in_valid never feeds in_ready.
    assign in_ready = !hfull_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: shifts each accepted word out one bit per clock with
// valid/last qualifiers; a one-entry hold buffer keeps back-to-back words gap-free.
module piso_serializer
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int unsigned     CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             accept;
    logic             last_bit;
    logic             hold_load;
    logic             hold_pop;
    logic [WIDTH-1:0] hreg;
    logic             hfull;
    logic [WIDTH-1:0] sreg_shifted;

    assign accept    = in_valid && in_ready;
    assign last_bit  = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    // On the last bit an accepted word bypasses the hold buffer straight into sreg.
    assign hold_load = accept && (state_q == SHIFT) && !last_bit;
    assign hold_pop  = last_bit && hfull;

    piso_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold_buf (
        .clk      (clk),
        .rst      (rst),
        .in       (in),
        .load     (hold_load),
        .pop      (hold_pop),
        .hreg     (hreg),
        .hfull    (hfull),
        .in_ready (in_ready)
    );

    always_comb begin
        if (MSB_FIRST) begin
            sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
        end else begin
            sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    sreg_d  = in;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (hfull) begin
                        sreg_d = hreg;
                    end else if (accept) begin
                        sreg_d = in;
                    end else begin
                        sreg_d  = '0;
                        state_d = IDLE;
                    end
                end else begin
                    sreg_d = sreg_shifted;
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ser_valid = (state_q == SHIFT);
    assign ser_last  = last_bit;
    assign ser_out   = ser_valid && (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);
    assign busy      = ser_valid || hfull;

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out stage that sits directly downstream of the 4-bit parallel register stage. Each accepted parallel word is shifted out one bit per clock with a valid/last qualifier. A one-entry hold buffer lets the next word be accepted while the current one is shifting, so back-to-back words stream with no idle cycle between them.

## Interface
Parameters:
- WIDTH, 4: bits per parallel word; must be ≥ 2.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset; **synchronous, active-low** (rst=0 resets on the next clk edge).
- in  input  WIDTH  parallel word from the upstream register stage.
- in_valid  input  1  in is valid this cycle.
- in_ready  output  1  stage can accept a word; the word transfers on an edge where in_valid && in_ready.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out carries a data bit.
- ser_last  output  1  ser_out is the final bit of its word.
- busy  output  1  shifter or hold buffer is occupied.

## Operation
- State machine has two states:
  - IDLE: shifter empty.
  - SHIFT: shifter holds a word; bit_cnt runs 0..WIDTH-1.
- Internal storage:
  - shift register sreg[WIDTH-1:0].
  - bit_cnt, width $clog2(WIDTH).
  - hold register hreg with flag hfull.
- Handshake: in_ready = !hfull. No combinational path from in_valid to in_ready.
- Accept in IDLE: word loads straight into sreg. bit_cnt=0. State → SHIFT.
- Accept in SHIFT, not on the last bit: word goes to hreg. hfull=1.
- End of word (SHIFT, bit_cnt==WIDTH-1):
  - If hfull: sreg←hreg, hfull←0, bit_cnt←0, stay in SHIFT. No gap.
  - Else, if a word is accepted on the same edge: it loads straight into sreg, stay in SHIFT. No gap.
  - Else: state → IDLE.
- Shifting:
  - MSB_FIRST=1: ser_out = sreg[WIDTH-1], shift left, fill with 0.
  - MSB_FIRST=0: ser_out = sreg[0], shift right, fill with 0.
- Outputs:
  - ser_valid = (state==SHIFT).
  - ser_last = ser_valid && bit_cnt==WIDTH-1.
  - ser_out forced to 0 when ser_valid=0.
  - busy = (state==SHIFT) || hfull.
- Reset values: state=IDLE, sreg=0, hreg=0, hfull=0, bit_cnt=0. Outputs ser_out=0, ser_valid=0, ser_last=0, in_ready=1, busy=0.
- Reset mid-word: the in-flight word and the held word are both discarded; no partial word completes. A word offered on the reset edge is not accepted.
- bit_cnt wrap-around: WIDTH-1 → 0 only via the end-of-word load; otherwise it is held at 0 in IDLE.

## Timing
- Latency: a word accepted at edge N puts its first bit on ser_out in cycle N+1. Its last bit appears in cycle N+WIDTH.
- Throughput: one word per WIDTH cycles sustained. ser_valid stays high continuously while words are supplied.
- in_ready drops the cycle after the hold buffer fills. It rises the cycle after the hold contents move into sreg.
- A word accepted in IDLE with the hold buffer empty never passes through hreg.

## Structure
- Shared package shift_pkg holds:
  - state enum {IDLE, SHIFT}.
  - default WIDTH constant, shared with the parallel register stage.
- One sub-module is natural: piso_hold_buf, the one-entry hold register with hfull and the in_ready logic. The FSM, counter and shifter stay in the top level.

## Test plan
All scenarios use WIDTH=4 and MSB_FIRST=1 unless stated.
1. Reset: hold rst=0 for 3 cycles with in_valid=1 and in=4'b1111 → ser_valid=0, ser_out=0, ser_last=0, in_ready=1, busy=0; no word is accepted.
2. Single word: pulse in_valid for one cycle with in=4'b1011 in IDLE → the next 4 cycles show ser_out 1,0,1,1 with ser_valid=1 and ser_last=1 only on the 4th; then ser_valid=0 and busy=0.
3. Back-to-back: offer 4'b1100 then 4'b0011 on consecutive cycles → 8 contiguous valid bits 1,1,0,0,0,0,1,1; ser_last on bits 4 and 8; in_ready=0 while hreg is full.
4. Backpressure: hold a third word 4'b1010 valid while hfull=1 → it is not accepted until the cycle after the hold buffer drains; it then appears as bits 9–12, 1,0,1,0.
5. Reset mid-word: assert rst=0 after 2 bits of 4'b1110 with 4'b0101 held in hreg → next cycle ser_valid=0, busy=0. After release, 4'b1001 serializes as 1,0,0,1 and neither 4'b1110 nor 4'b0101 ever appears.
6. LSB-first: MSB_FIRST=0, in=4'b1101 → ser_out 1,0,1,1 with ser_last on the 4th bit.
